// File: rtl/add4_bist.sv
// add4_bist: LFSR stimulus source and response checker for the combinational add4 adder.
// Latency: a run of N_VECTORS checks ends with done raised N_VECTORS+1 edges after start is sampled.
// Backpressure: none; start is ignored in RUN. Define ADD4_BIST_STOP_ON_FAIL_EN to halt on the first mismatch.
module add4_bist #(
    parameter int          N_VECTORS = 16,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    input  logic [3:0] s_i,
    input  logic       cout_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] vec_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] N_LAST   = 8'(N_VECTORS);

    state_t     state, state_nxt;
    logic [7:0] lfsr, lfsr_nxt, lfsr_step;
    logic [7:0] err_nxt, vec_nxt;
    logic       mismatch;

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign mismatch  = {cout_i, s_i} != ({1'b0, a_o} + {1'b0, b_o});

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        err_nxt   = err_count;
        vec_nxt   = vec_count;
        case (state)
            IDLE: begin
                lfsr_nxt = SEED_EFF;
                err_nxt  = 8'd0;
                vec_nxt  = 8'd0;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                vec_nxt = vec_count + 8'd1;
                if (mismatch && err_count != 8'hFF) err_nxt = err_count + 8'd1;
`ifdef ADD4_BIST_STOP_ON_FAIL_EN
                // Freeze the operands of the failing vector for inspection.
                if (mismatch) begin
                    state_nxt = DONE;
                end else begin
                    lfsr_nxt = lfsr_step;
                    if (vec_nxt == N_LAST) state_nxt = DONE;
                end
`else
                lfsr_nxt = lfsr_step;
                if (vec_nxt == N_LAST) state_nxt = DONE;
`endif
            end
            DONE: begin
                if (start) begin
                    lfsr_nxt  = SEED_EFF;
                    err_nxt   = 8'd0;
                    vec_nxt   = 8'd0;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED_EFF;
            err_count <= 8'd0;
            vec_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            err_count <= err_nxt;
            vec_count <= vec_nxt;
        end
    end

    assign a_o  = lfsr[7:4];
    assign b_o  = lfsr[3:0];
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 8'd0);

endmodule

// File: doc/add4_bist.md
# add4_bist

Self-test controller for the `add4` adder: generates pseudo-random 4-bit operand pairs with an LFSR, drives them into `add4`, and checks the returned sum and carry against an internal reference. It is the synthesizable counterpart to the random-stimulus bench, and sits beside `add4` as its stimulus source and response checker. It reports a vector count, an error count and a pass/fail verdict.

## Interface
- `N_VECTORS`, 16: number of vectors per run; legal range 1..255.
- `SEED`, 8'hA5: LFSR start value; a value of 0 is replaced by 8'h01.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request.
- `a_o` out 4: operand A to `add4`, equal to `lfsr[7:4]`.
- `b_o` out 4: operand B to `add4`, equal to `lfsr[3:0]`.
- `s_i` in 4: sum returned by `add4`.
- `cout_i` in 1: carry returned by `add4`.
- `busy` out 1: high while state is RUN.
- `done` out 1: high while state is DONE.
- `pass` out 1: `done && err_count==0`.
- `err_count` out 8: number of mismatches; saturates at 255.
- `vec_count` out 8: number of vectors checked in the current or last run.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - `start`=1 moves to RUN.
  - LFSR loads `SEED`; counts clear.
- **RUN**, on every edge:
  - Compare `{cout_i,s_i}` with the 5-bit sum `{1'b0,a_o}+{1'b0,b_o}`.
  - On a mismatch, increment `err_count` (saturating).
  - Increment `vec_count`.
  - Step the LFSR.
  - When `vec_count` reaches `N_VECTORS`, move to DONE.
- **LFSR**
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Next value is `{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - Maximal length: period 255; the all-zero state is never reached.
- **DONE**
  - Results, `a_o` and `b_o` hold.
  - `start`=1 restarts: reseed, clear counts, go to RUN.
- `start` is ignored while in RUN.
- `add4` is purely combinational. The response is checked in the same cycle its operands are driven.

## Timing
- Reset values:
  - `a_o`=4'hA, `b_o`=4'h5 (from `SEED`).
  - `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `vec_count`=0.
- `start` is sampled at edge E0. At E0: `busy`=1, the LFSR holds `SEED`, and the first vector is presented.
- The vector for check k is stable from edge E(k-1) to E(k) and is compared at E(k).
- At edge E(N_VECTORS): `busy`=0, `done`=1, `vec_count`=N_VECTORS.
- Latency from `start` to `done` is N_VECTORS+1 edges.
- A mismatch on the last vector is counted before `done` rises; `pass` is valid in the same cycle as `done`.
- `rst_n` asserted mid-run:
  - Immediately returns to IDLE with reset values.
  - No partial result is kept.
- `start` held high for several cycles starts exactly one run. Any re-trigger is ignored while in RUN; once in DONE, `start` high triggers a new run.

## Configuration
- `ADD4_BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch moves RUN→DONE at that edge.
  - `err_count`=1 and `vec_count` includes the failing vector.
  - The LFSR does not step, so `a_o`/`b_o` hold the failing operands for debug.
  - `pass`=0.
- Not defined:
  - All `N_VECTORS` vectors are always applied.
  - `err_count` accumulates.
  - The final `a_o`/`b_o` are the vector after the last one checked.

## Test plan
- Reset with `SEED`=8'hA5 → `a_o`=A, `b_o`=5; all status outputs 0; after `start`, the first check expects 0x0F. The second vector is `a_o`=4, `b_o`=A, expecting 0x0E with `cout`=0.
- Good `add4` connected, `N_VECTORS`=16 → `done` rises 17 edges after `start`; `pass`=1, `err_count`=0, `vec_count`=16.
- `cout_i` forced to 0 with `N_VECTORS`=255 → `err_count` equals the number of vectors with a+b>15 across the LFSR sequence, as computed by a bench model; `pass`=0.
- `ADD4_BIST_STOP_ON_FAIL_EN` defined, `s_i` bit 0 forced wrong on vector 3 → `done` at the 3rd check edge; `err_count`=1, `vec_count`=3; `a_o`/`b_o` show the vector-3 operands.
- `rst_n` pulsed low at vector 8 of 16 → all outputs return to reset values immediately; a new `start` then gives a clean full run ending with `pass`=1.
- `start` pulsed during RUN, then again in DONE → the first pulse has no effect; the second reseeds and repeats the identical vector sequence.
